// File: rtl/fft_ram_writer_pkg.sv
// ============================================================================
// Module : fft_ram_writer_pkg
// Brief  : Shared constants, state types and bin packing for the FFT RAM writer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_ram_writer_pkg;

  localparam int NCH    = 4;
  localparam int NPOINT = 1024;
  localparam int AW     = $clog2(NPOINT);
  localparam int DW     = 16;
  localparam int WW     = 2 * DW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DONE = 2'd1,
    HOLD = 2'd2
  } glb_state_t;

  function automatic logic [WW-1:0] pack_bin(input logic [DW-1:0] re,
                                             input logic [DW-1:0] im);
    return {re, im};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_ram_writer_if.sv
// ============================================================================
// Module : fft_ram_writer_if
// Brief  : FFT source streams, RAM write ports and frame handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fft_ram_writer_if;
  import fft_ram_writer_pkg::*;

  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_sop;
  logic [NCH-1:0]         in_eop;
  logic [NCH-1:0][DW-1:0] in_real;
  logic [NCH-1:0][DW-1:0] in_imag;
  logic                   sink_ready;
  logic [NCH-1:0]         wren;
  logic [NCH-1:0][AW-1:0] wraddress;
  logic [NCH-1:0][WW-1:0] data;
  logic                   fftdone;
  logic                   done;
  logic                   frame_err;

  modport slave (
    input  in_valid, in_sop, in_eop, in_real, in_imag, done,
    output sink_ready, wren, wraddress, data, fftdone, frame_err
  );

  modport master (
    output in_valid, in_sop, in_eop, in_real, in_imag, done,
    input  sink_ready, wren, wraddress, data, fftdone, frame_err
  );

endinterface

`default_nettype wire

// File: rtl/fft_ram_writer_ch_writer.sv
// ============================================================================
// Module : fft_ch_writer
// Brief  : One channel: frame tracking FSM, bin address counter, write register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_ch_writer
  import fft_ram_writer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept_i,
  input  logic          sop_i,
  input  logic          eop_i,
  input  logic [DW-1:0] real_i,
  input  logic [DW-1:0] imag_i,
  input  logic          release_i,
  output logic          wren_o,
  output logic [AW-1:0] wraddress_o,
  output logic [WW-1:0] data_o,
  output logic          full_o,
  output logic          err_o
);

  localparam logic [AW-1:0] LAST_BIN = AW'(NPOINT - 1);

  ch_state_t     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wren_q, wren_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [WW-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    data_d   = data_q;
    err_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_i && sop_i) begin
          wren_d   = 1'b1;
          wraddr_d = '0;
          data_d   = pack_bin(real_i, imag_i);
          addr_d   = AW'(1);
          state_d  = ACTIVE;
        end
      end

      ACTIVE: begin
        if (accept_i) begin
          wren_d = 1'b1;
          data_d = pack_bin(real_i, imag_i);
          if (sop_i) begin
            // A fresh sop mid-frame wins: restart the frame at bin 0.
            wraddr_d = '0;
            addr_d   = AW'(1);
            err_o    = 1'b1;
          end else begin
            wraddr_d = addr_q;
            addr_d   = addr_q + AW'(1);
            if (eop_i) begin
              if (addr_q == LAST_BIN) begin
                state_d = FULL;
              end else begin
                state_d = IDLE;
                err_o   = 1'b1;
              end
            end else if (addr_q == LAST_BIN) begin
              state_d = IDLE;
              err_o   = 1'b1;
            end
          end
        end
      end

      FULL: ;

      default: state_d = IDLE;
    endcase

    if (release_i) begin
      state_d = IDLE;
      addr_d  = '0;
    end
  end

  assign wren_o      = wren_q;
  assign wraddress_o = wraddr_q;
  assign data_o      = data_q;
  assign full_o      = (state_q == FULL);

endmodule

`default_nettype wire

// File: rtl/fft_ram_writer.sv
// ============================================================================
// Module : fft_ram_writer
// Brief  : Stores NCH FFT frames into per-channel RAMs and hands the set downstream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_ram_writer
  import fft_ram_writer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  fft_ram_writer_if.slave bus
);

  glb_state_t glb_q, glb_d;
  logic       sink_ready_q, sink_ready_d;
  logic       fftdone_q, fftdone_d;
  logic       frame_err_q, frame_err_d;
  logic       release_ch;

  logic [NCH-1:0]         ch_full;
  logic [NCH-1:0]         ch_err;
  logic [NCH-1:0]         ch_wren;
  logic [NCH-1:0][AW-1:0] ch_addr;
  logic [NCH-1:0][WW-1:0] ch_data;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      fft_ch_writer u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept_i    (bus.in_valid[c] & sink_ready_q),
        .sop_i       (bus.in_sop[c]),
        .eop_i       (bus.in_eop[c]),
        .real_i      (bus.in_real[c]),
        .imag_i      (bus.in_imag[c]),
        .release_i   (release_ch),
        .wren_o      (ch_wren[c]),
        .wraddress_o (ch_addr[c]),
        .data_o      (ch_data[c]),
        .full_o      (ch_full[c]),
        .err_o       (ch_err[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glb_q        <= FILL;
      sink_ready_q <= 1'b0;
      fftdone_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      glb_q        <= glb_d;
      sink_ready_q <= sink_ready_d;
      fftdone_q    <= fftdone_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge the global FSM moves.
  always_comb begin
    glb_d      = glb_q;
    release_ch = 1'b0;

    case (glb_q)
      FILL:    if (&ch_full) glb_d = DONE;
      DONE:    glb_d = HOLD;
      HOLD: begin
        if (bus.done) begin
          glb_d      = FILL;
          release_ch = 1'b1;
        end
      end
      default: glb_d = FILL;
    endcase

    sink_ready_d = (glb_d == FILL);
    fftdone_d    = (glb_d == DONE);
    frame_err_d  = (glb_d == DONE) ? 1'b0 : (frame_err_q | (|ch_err));
  end

  assign bus.sink_ready = sink_ready_q;
  assign bus.fftdone    = fftdone_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.wren       = ch_wren;
  assign bus.wraddress  = ch_addr;
  assign bus.data       = ch_data;

endmodule

`default_nettype wire
